// File: rtl/fp_pkg.sv
// Shared FP operand definitions: field widths per format and the classification record
// carried alongside each unpacked operand.
package fp_pkg;

  localparam int unsigned FP32_EXP_BITS  = 8;
  localparam int unsigned FP32_FRAC_BITS = 23;
  localparam int unsigned FP64_EXP_BITS  = 11;
  localparam int unsigned FP64_FRAC_BITS = 52;

  // Width-independent part of a normalized operand; sign/exp/mant widths depend on the format
  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_snan;
    logic was_subnormal;
  } fp_class_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_all_zero
);

  always_comb begin
    o_count = CNT_W'(WIDTH);
    // Scanning upward lets the highest set bit win
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CNT_W'(WIDTH - 1 - i);
    end
  end

  assign o_all_zero = ~|i_data;

endmodule

// File: rtl/fp_operand_unpacker.sv
// Splits a packed IEEE-754 operand into sign, adjusted exponent, mantissa and class flags.
module fp_operand_unpacker
  import fp_pkg::*;
#(
  parameter int unsigned FP_WIDTH  = 32,
  parameter int unsigned EXP_BITS  = 8,
  parameter int unsigned FRAC_BITS = 23,
  parameter int unsigned MANT_BITS = FRAC_BITS + 1
) (
  input  logic [FP_WIDTH-1:0]   i_operand,
  output logic                  o_sign,
  output logic [EXP_BITS+1:0]   o_exp_adj,
  output logic [MANT_BITS-1:0]  o_mant,
  output fp_class_t             o_class
);

  logic [EXP_BITS-1:0]  exp_f;
  logic [FRAC_BITS-1:0] frac_f;
  logic                 exp_zero, exp_ones, frac_zero;

  assign o_sign    = i_operand[FP_WIDTH-1];
  assign exp_f     = i_operand[FP_WIDTH-2:FRAC_BITS];
  assign frac_f    = i_operand[FRAC_BITS-1:0];
  assign exp_zero  = (exp_f == '0);
  assign exp_ones  = (exp_f == '1);
  assign frac_zero = (frac_f == '0);

  always_comb begin
    o_class               = '0;
    o_class.is_zero       = exp_zero & frac_zero;
    o_class.was_subnormal = exp_zero & ~frac_zero;
    o_class.is_inf        = exp_ones & frac_zero;
    o_class.is_nan        = exp_ones & ~frac_zero;
    o_class.is_snan       = exp_ones & ~frac_zero & ~frac_f[FRAC_BITS-1];
  end

  // Subnormals share the exponent of the smallest normal; zero keeps a zero exponent
  always_comb begin
    if (exp_zero) o_exp_adj = frac_zero ? '0 : (EXP_BITS+2)'(1);
    else          o_exp_adj = {2'b00, exp_f};
  end

  assign o_mant = {~exp_zero, frac_f};

endmodule

// File: rtl/fp_operand_normalizer.sv
// Two-stage valid/ready pipeline: unpack + leading-zero count, then shift out the zeros
// and fold the count into the exponent so finite non-zero results have mant[MSB]=1.
module fp_operand_normalizer
  import fp_pkg::*;
#(
  parameter int unsigned FP_WIDTH  = 32,
  parameter int unsigned EXP_BITS  = (FP_WIDTH == 32) ? FP32_EXP_BITS : FP64_EXP_BITS,
  parameter int unsigned FRAC_BITS = (FP_WIDTH == 32) ? FP32_FRAC_BITS : FP64_FRAC_BITS,
  parameter int unsigned MANT_BITS = FRAC_BITS + 1,
  parameter int unsigned TAG_BITS  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [FP_WIDTH-1:0]   i_operand,
  input  logic [TAG_BITS-1:0]   i_tag,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_sign,
  output logic [EXP_BITS+1:0]   o_exp,
  output logic [MANT_BITS-1:0]  o_mant,
  output logic                  o_is_zero,
  output logic                  o_is_inf,
  output logic                  o_is_nan,
  output logic                  o_is_snan,
  output logic                  o_was_subnormal,
  output logic [TAG_BITS-1:0]   o_tag
);

  localparam int unsigned XW    = EXP_BITS + 2;
  localparam int unsigned LZC_W = $clog2(MANT_BITS + 1);

  logic                 u_sign, u_all_zero;
  logic [XW-1:0]        u_exp;
  logic [MANT_BITS-1:0] u_mant;
  logic [LZC_W-1:0]     u_lzc;
  fp_class_t            u_cls;

  logic                 a_valid_q, a_valid_d, a_sign_q, a_sign_d, a_mzero_q, a_mzero_d;
  logic [XW-1:0]        a_exp_q, a_exp_d;
  logic [MANT_BITS-1:0] a_mant_q, a_mant_d;
  logic [LZC_W-1:0]     a_lzc_q, a_lzc_d;
  fp_class_t            a_cls_q, a_cls_d;
  logic [TAG_BITS-1:0]  a_tag_q, a_tag_d;

  logic                 b_valid_q, b_valid_d, b_sign_q, b_sign_d;
  logic [XW-1:0]        b_exp_q, b_exp_d;
  logic [MANT_BITS-1:0] b_mant_q, b_mant_d;
  fp_class_t            b_cls_q, b_cls_d;
  logic [TAG_BITS-1:0]  b_tag_q, b_tag_d;

  logic a_adv, a_open;

  fp_operand_unpacker #(
    .FP_WIDTH (FP_WIDTH),
    .EXP_BITS (EXP_BITS),
    .FRAC_BITS(FRAC_BITS),
    .MANT_BITS(MANT_BITS)
  ) u_unpack (
    .i_operand(i_operand),
    .o_sign   (u_sign),
    .o_exp_adj(u_exp),
    .o_mant   (u_mant),
    .o_class  (u_cls)
  );

  fp_lzc #(
    .WIDTH(MANT_BITS),
    .CNT_W(LZC_W)
  ) u_lzc_i (
    .i_data    (u_mant),
    .o_count   (u_lzc),
    .o_all_zero(u_all_zero)
  );

  assign a_adv   = ~b_valid_q | i_ready;
  assign a_open  = ~a_valid_q | a_adv;
  assign o_ready = a_open & ~i_flush;

  always_comb begin
    a_valid_d = a_valid_q;  a_sign_d = a_sign_q;  a_mzero_d = a_mzero_q;
    a_exp_d   = a_exp_q;    a_mant_d = a_mant_q;  a_lzc_d   = a_lzc_q;
    a_cls_d   = a_cls_q;    a_tag_d  = a_tag_q;
    b_valid_d = b_valid_q;  b_sign_d = b_sign_q;  b_exp_d   = b_exp_q;
    b_mant_d  = b_mant_q;   b_cls_d  = b_cls_q;   b_tag_d   = b_tag_q;
    if (i_flush) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end else begin
      if (a_adv) begin
        b_valid_d = a_valid_q;
        if (a_valid_q) begin
          b_sign_d = a_sign_q;
          // An all-zero mantissa would otherwise pick up -MANT_BITS in the exponent
          b_exp_d  = a_mzero_q ? '0 : a_exp_q - XW'(a_lzc_q);
          b_mant_d = a_mant_q << a_lzc_q;
          b_cls_d  = a_cls_q;
          b_tag_d  = a_tag_q;
        end
      end
      if (a_open) begin
        a_valid_d = i_valid;
        if (i_valid) begin
          a_sign_d  = u_sign;
          a_exp_d   = u_exp;
          a_mant_d  = u_mant;
          a_lzc_d   = u_lzc;
          a_mzero_d = u_all_zero;
          a_cls_d   = u_cls;
          a_tag_d   = i_tag;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_valid_q <= 1'b0;  a_sign_q <= 1'b0;  a_mzero_q <= 1'b0;
      a_exp_q   <= '0;    a_mant_q <= '0;    a_lzc_q   <= '0;
      a_cls_q   <= '0;    a_tag_q  <= '0;
      b_valid_q <= 1'b0;  b_sign_q <= 1'b0;  b_exp_q   <= '0;
      b_mant_q  <= '0;    b_cls_q  <= '0;    b_tag_q   <= '0;
    end else begin
      a_valid_q <= a_valid_d;  a_sign_q <= a_sign_d;  a_mzero_q <= a_mzero_d;
      a_exp_q   <= a_exp_d;    a_mant_q <= a_mant_d;  a_lzc_q   <= a_lzc_d;
      a_cls_q   <= a_cls_d;    a_tag_q  <= a_tag_d;
      b_valid_q <= b_valid_d;  b_sign_q <= b_sign_d;  b_exp_q   <= b_exp_d;
      b_mant_q  <= b_mant_d;   b_cls_q  <= b_cls_d;   b_tag_q   <= b_tag_d;
    end
  end

  assign o_valid         = b_valid_q;
  assign o_sign          = b_sign_q;
  assign o_exp           = b_exp_q;
  assign o_mant          = b_mant_q;
  assign o_is_zero       = b_cls_q.is_zero;
  assign o_is_inf        = b_cls_q.is_inf;
  assign o_is_nan        = b_cls_q.is_nan;
  assign o_is_snan       = b_cls_q.is_snan;
  assign o_was_subnormal = b_cls_q.was_subnormal;
  assign o_tag           = b_tag_q;

endmodule

// File: tb/tb_fp_operand_normalizer.sv
// Drives an fp32 and an fp64 normalizer in lockstep and checks both against a
// doubling-loop reference model plus directed handshake/flush/reset scenarios.
module tb_fp_operand_normalizer;

  typedef struct {
    bit              sign;
    longint          ex;
    longint unsigned mant;
    bit [4:0]        flags;   // {zero, inf, nan, snan, subnormal}
    bit [3:0]        tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, valid, ready;
  logic [31:0] op32;
  logic [63:0] op64;
  logic [3:0]  tag;

  logic        o_ready32, o_valid32, o_sign32, z32, inf32, nan32, snan32, sub32;
  logic [9:0]  o_exp32;
  logic [23:0] o_mant32;
  logic [3:0]  o_tag32;
  logic        o_ready64, o_valid64, o_sign64, z64, inf64, nan64, snan64, sub64;
  logic [12:0] o_exp64;
  logic [52:0] o_mant64;
  logic [3:0]  o_tag64;

  int n_checks = 0;
  int n_errors = 0;
  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  fp_operand_normalizer #(.FP_WIDTH(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready32),
    .i_operand(op32), .i_tag(tag), .o_valid(o_valid32), .i_ready(ready),
    .o_sign(o_sign32), .o_exp(o_exp32), .o_mant(o_mant32), .o_is_zero(z32),
    .o_is_inf(inf32), .o_is_nan(nan32), .o_is_snan(snan32),
    .o_was_subnormal(sub32), .o_tag(o_tag32));

  fp_operand_normalizer #(.FP_WIDTH(64)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready64),
    .i_operand(op64), .i_tag(tag), .o_valid(o_valid64), .i_ready(ready),
    .o_sign(o_sign64), .o_exp(o_exp64), .o_mant(o_mant64), .o_is_zero(z64),
    .o_is_inf(inf64), .o_is_nan(nan64), .o_is_snan(snan64),
    .o_was_subnormal(sub64), .o_tag(o_tag64));

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic exp_t model(input logic [63:0] op, input bit w64, input logic [3:0] t);
    exp_t            r;
    int              eb, fb;
    longint          e, emax;
    longint unsigned hidden, frac;
    eb     = w64 ? 11 : 8;
    fb     = w64 ? 52 : 23;
    hidden = 64'd1 << fb;
    frac   = op & (hidden - 1);
    e      = longint'((op >> fb) & ((64'd1 << eb) - 1));
    emax   = (longint'(1) << eb) - 1;
    r.sign  = w64 ? op[63] : op[31];
    r.tag   = t;
    r.flags = '0;
    if (e == 0 && frac == 0) begin
      r.ex = 0; r.mant = 0; r.flags = 5'b10000;
    end else if (e == emax) begin
      r.ex = emax; r.mant = hidden + frac;
      if (frac == 0) r.flags = 5'b01000;
      else begin
        r.flags[2] = 1'b1;
        r.flags[1] = (frac < hidden / 2);
      end
    end else if (e != 0) begin
      r.ex = e; r.mant = hidden + frac;
    end else begin
      r.ex = 1; r.mant = frac; r.flags[0] = 1'b1;
      while (r.mant < hidden) begin
        r.mant = r.mant * 2;
        r.ex   = r.ex - 1;
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] rand_op(input bit w64);
    logic [63:0] r, emask, smask;
    int          eb, fb;
    eb    = w64 ? 11 : 8;
    fb    = w64 ? 52 : 23;
    r     = {$urandom, $urandom};
    if (!w64) r[63:32] = '0;
    emask = ((64'd1 << eb) - 1) << fb;
    smask = 64'd1 << (eb + fb);
    case ($urandom_range(0, 4))
      1: r = r & ~emask;
      2: r = r | emask;
      3: r = (r & smask) | (64'd1 << $urandom_range(0, fb - 1));
      4: r = r & smask;
      default: ;
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst || flush) begin
      q32.delete();
      q64.delete();
    end else begin
      if (o_valid32) begin
        if (q32.size() == 0) check_eq("spurious32", 64'(q32.size()), 64'd1);
        else begin
          check_eq("sb32_sign", 64'(o_sign32), 64'(q32[0].sign));
          check_eq("sb32_exp", 64'(longint'($signed(o_exp32))), 64'(q32[0].ex));
          check_eq("sb32_mant", 64'(o_mant32), q32[0].mant);
          check_eq("sb32_flags", 64'({z32, inf32, nan32, snan32, sub32}), 64'(q32[0].flags));
          check_eq("sb32_tag", 64'(o_tag32), 64'(q32[0].tag));
          if (ready) void'(q32.pop_front());
        end
      end
      if (o_valid64) begin
        if (q64.size() == 0) check_eq("spurious64", 64'(q64.size()), 64'd1);
        else begin
          check_eq("sb64_sign", 64'(o_sign64), 64'(q64[0].sign));
          check_eq("sb64_exp", 64'(longint'($signed(o_exp64))), 64'(q64[0].ex));
          check_eq("sb64_mant", 64'(o_mant64), q64[0].mant);
          check_eq("sb64_flags", 64'({z64, inf64, nan64, snan64, sub64}), 64'(q64[0].flags));
          check_eq("sb64_tag", 64'(o_tag64), 64'(q64[0].tag));
          if (ready) void'(q64.pop_front());
        end
      end
      if (valid && o_ready32) begin
        q32.push_back(model({32'd0, op32}, 1'b0, tag));
        q64.push_back(model(op64, 1'b1, tag));
      end
    end
  end

  task automatic send1(input logic [31:0] o32, input logic [63:0] o64, input logic [3:0] t);
    valid = 1'b1; op32 = o32; op64 = o64; tag = t; ready = 1'b1;
    step();
    valid = 1'b0;
    check_eq("lat1_valid", 64'(o_valid32), 64'd0);
    step();
    check_eq("lat2_valid", 64'(o_valid32), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b1; op32 = '0; op64 = '0; tag = '0;
    step(); step();
    check_eq("rst_valid", 64'(o_valid32), 64'd0);
    check_eq("rst_exp", 64'(o_exp32), 64'd0);
    check_eq("rst_mant", 64'(o_mant32), 64'd0);
    rst = 1'b0;
    check_eq("rst_ready", 64'(o_ready32), 64'd1);

    send1(32'h3F80_0000, 64'h3FF0_0000_0000_0000, 4'd1);
    check_eq("one_exp", 64'(o_exp32), 64'd127);
    check_eq("one_mant", 64'(o_mant32), 64'h80_0000);
    check_eq("one_flags", 64'({z32, inf32, nan32, snan32, sub32}), 64'd0);
    check_eq("one64_exp", 64'(o_exp64), 64'd1023);
    check_eq("one64_mant", 64'(o_mant64), 64'd1 << 52);
    step();

    send1(32'h0000_0001, 64'h0000_0000_0000_0001, 4'd2);
    check_eq("min_exp", 64'(o_exp32), 64'h3EA);
    check_eq("min_mant", 64'(o_mant32), 64'h80_0000);
    check_eq("min_sub", 64'(sub32), 64'd1);
    check_eq("min64_exp", 64'(o_exp64), 64'h1FCD);
    check_eq("min64_mant", 64'(o_mant64), 64'd1 << 52);
    step();

    send1(32'h0040_0000, 64'd0, 4'd3);
    check_eq("sub_exp", 64'(o_exp32), 64'd0);
    check_eq("sub_mant", 64'(o_mant32), 64'h80_0000);
    step();

    send1(32'h8000_0000, 64'd0, 4'd4);
    check_eq("nz_sign", 64'(o_sign32), 64'd1);
    check_eq("nz_zero", 64'(z32), 64'd1);
    check_eq("nz_exp", 64'(o_exp32), 64'd0);
    check_eq("nz_mant", 64'(o_mant32), 64'd0);
    step();

    send1(32'h7F80_0001, 64'd0, 4'd5);
    check_eq("snan_nan", 64'(nan32), 64'd1);
    check_eq("snan_snan", 64'(snan32), 64'd1);
    check_eq("snan_mant", 64'(o_mant32), 64'h80_0001);
    step();

    // Back-pressure: three back-to-back tags with downstream stalled for four cycles
    ready = 1'b0; valid = 1'b1; op32 = 32'h4000_0000; op64 = '0; tag = 4'd1;
    step();
    tag = 4'd2;
    step();
    tag = 4'd3;
    check_eq("bp_ready_low", 64'(o_ready32), 64'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("bp_hold_tag", 64'(o_tag32), 64'd1);
      check_eq("bp_hold_valid", 64'(o_valid32), 64'd1);
    end
    ready = 1'b1;
    step();
    valid = 1'b0;
    check_eq("bp_order2", 64'(o_tag32), 64'd2);
    step();
    check_eq("bp_order3", 64'(o_tag32), 64'd3);
    step();
    check_eq("bp_drained", 64'(o_valid32), 64'd0);

    // Flush with two in flight and a third presented in the flush cycle
    ready = 1'b0; valid = 1'b1; tag = 4'd6;
    step();
    tag = 4'd7;
    step();
    tag = 4'd8; flush = 1'b1;
    check_eq("fl_ready_low", 64'(o_ready32), 64'd0);
    step();
    flush = 1'b0; valid = 1'b0; ready = 1'b1;
    check_eq("fl_valid0", 64'(o_valid32), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("fl_no_out", 64'(o_valid32), 64'd0);
    end

    // Reset with two in flight
    ready = 1'b0; valid = 1'b1; tag = 4'd9; op32 = 32'h3F80_0000;
    step();
    step();
    valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; ready = 1'b1;
    check_eq("mrst_valid", 64'(o_valid32), 64'd0);
    check_eq("mrst_mant", 64'(o_mant32), 64'd0);
    check_eq("mrst_tag", 64'(o_tag32), 64'd0);
    check_eq("mrst_ready", 64'(o_ready32), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("mrst_no_out", 64'(o_valid32), 64'd0);
    end

    for (int i = 0; i < 800; i++) begin
      valid = ($urandom_range(0, 3) != 0);
      ready = ($urandom_range(0, 3) != 0);
      op32  = 32'(rand_op(1'b0));
      op64  = rand_op(1'b1);
      tag   = 4'($urandom);
      step();
    end

    valid = 1'b0; ready = 1'b1;
    for (int i = 0; i < 20 && (q32.size() != 0 || q64.size() != 0); i++) step();
    check_eq("drain32", 64'(q32.size()), 64'd0);
    check_eq("drain64", 64'(q64.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
